// File: rtl/toggle_cover_scheduler.sv
// Toggle-coverage report scheduler: first-hit capture per point, round-robin
// group arbitration onto a single valid/ready report port, covered-point count.
module toggle_cover_scheduler #(
    parameter int unsigned         W           = 20,
    parameter int unsigned         N_GROUPS    = 4,
    parameter int unsigned         IDX_W       = 64,
    parameter logic [IDX_W-1:0]    COVER_INDEX = '0,
    parameter int unsigned         CNT_W       = $clog2(N_GROUPS*W+1)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  clear,
    input  logic [N_GROUPS*W-1:0] valid,
    output logic                  report_valid,
    output logic [IDX_W-1:0]      report_index,
    input  logic                  report_ready,
    output logic [CNT_W-1:0]      hit_count,
    output logic                  all_covered
);

    localparam int unsigned P     = N_GROUPS * W;
    localparam int unsigned PT_W  = (P > 1) ? $clog2(P) : 1;
    localparam int unsigned PTR_W = (N_GROUPS > 1) ? $clog2(N_GROUPS) : 1;

    logic [P-1:0]        covered, covered_nxt;
    logic [P-1:0]        pending, pending_nxt;
    logic [PT_W-1:0]     slot_pt, slot_pt_nxt;
    logic [PTR_W-1:0]    rr_ptr, rr_ptr_nxt;
    logic                report_valid_nxt;
    logic [IDX_W-1:0]    report_index_nxt;
    logic [CNT_W-1:0]    hit_count_nxt;
    logic                all_covered_nxt;

    logic [P-1:0]        slot_onehot;
    logic [P-1:0]        new_hits;
    logic [N_GROUPS-1:0] grp_any;
    logic                sel_found;
    logic [PT_W-1:0]     sel_pt;
    logic [P-1:0]        sel_onehot;
    logic [PTR_W-1:0]    sel_rr;
    logic                handshake;
    logic                load_en;

    // Per-group "has pending work" flags
    always_comb begin
        grp_any = '0;
        for (int g = 0; g < int'(N_GROUPS); g++) begin
            grp_any[g] = |pending[g*W +: W];
        end
    end

    // Round-robin group pick: first pass from rr_ptr upward, second pass wraps to 0
    always_comb begin
        sel_found = 1'b0;
        sel_pt    = '0;
        sel_rr    = '0;
        for (int pass = 0; pass < 2; pass++) begin
            for (int g = 0; g < int'(N_GROUPS); g++) begin
                if (!sel_found && grp_any[g] && (pass == 1 || g >= int'(rr_ptr))) begin
                    sel_found = 1'b1;
                    sel_rr    = PTR_W'((g + 1) % int'(N_GROUPS));
                    for (int b = int'(W) - 1; b >= 0; b--) begin
                        if (pending[g*int'(W) + b]) begin
                            sel_pt = PT_W'(g*int'(W) + b);
                        end
                    end
                end
            end
        end
        sel_onehot = sel_found ? (P'(1) << sel_pt) : '0;
    end

    // Next-state: capture, handshake, slot load; clear overrides all of it
    always_comb begin
        slot_onehot      = report_valid ? (P'(1) << slot_pt) : '0;
        handshake        = report_valid && report_ready;
        load_en          = !report_valid || handshake;
        new_hits         = enable ? (valid & ~covered & ~pending & ~slot_onehot) : '0;

        covered_nxt      = covered;
        pending_nxt      = pending | new_hits;
        report_valid_nxt = report_valid;
        report_index_nxt = report_index;
        slot_pt_nxt      = slot_pt;
        rr_ptr_nxt       = rr_ptr;
        hit_count_nxt    = hit_count;

        if (handshake) begin
            covered_nxt   = covered | slot_onehot;
            hit_count_nxt = hit_count + CNT_W'(1);
        end

        if (load_en) begin
            report_valid_nxt = sel_found;
            if (sel_found) begin
                pending_nxt      = pending_nxt & ~sel_onehot;
                slot_pt_nxt      = sel_pt;
                report_index_nxt = COVER_INDEX + IDX_W'(sel_pt);
                rr_ptr_nxt       = sel_rr;
            end
        end

        if (clear) begin
            covered_nxt      = '0;
            pending_nxt      = '0;
            report_valid_nxt = 1'b0;
            report_index_nxt = report_index;
            slot_pt_nxt      = slot_pt;
            rr_ptr_nxt       = rr_ptr;
            hit_count_nxt    = '0;
        end

        all_covered_nxt = (hit_count_nxt == CNT_W'(P));
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            covered      <= '0;
            pending      <= '0;
            report_valid <= 1'b0;
            report_index <= '0;
            slot_pt      <= '0;
            rr_ptr       <= '0;
            hit_count    <= '0;
            all_covered  <= 1'b0;
        end else begin
            covered      <= covered_nxt;
            pending      <= pending_nxt;
            report_valid <= report_valid_nxt;
            report_index <= report_index_nxt;
            slot_pt      <= slot_pt_nxt;
            rr_ptr       <= rr_ptr_nxt;
            hit_count    <= hit_count_nxt;
            all_covered  <= all_covered_nxt;
        end
    end

endmodule

// File: tb/tb_toggle_cover_scheduler.sv
// Scoreboard bench for toggle_cover_scheduler: stimulus pushes expected report
// indices, a negedge monitor pops and compares on every accepted report.
module tb_toggle_cover_scheduler;

    localparam int unsigned W        = 20;
    localparam int unsigned N_GROUPS = 4;
    localparam int unsigned P        = W * N_GROUPS;
    localparam int unsigned IDX_W    = 64;
    localparam int unsigned CNT_W    = $clog2(P + 1);

    logic              clock;
    logic              reset;
    logic              enable;
    logic              clear;
    logic [P-1:0]      valid;
    logic              report_valid;
    logic [IDX_W-1:0]  report_index;
    logic              report_ready;
    logic [CNT_W-1:0]  hit_count;
    logic              all_covered;

    logic [63:0] exp_q[$];
    int          checks = 0;
    int          errors = 0;

    toggle_cover_scheduler #(
        .W(W), .N_GROUPS(N_GROUPS), .IDX_W(IDX_W), .COVER_INDEX('0), .CNT_W(CNT_W)
    ) dut (
        .clock(clock), .reset(reset), .enable(enable), .clear(clear), .valid(valid),
        .report_valid(report_valid), .report_index(report_index),
        .report_ready(report_ready), .hit_count(hit_count), .all_covered(all_covered)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every accepted report (dropped when clear is high) must match the queue head
    always @(negedge clock) begin
        if (!reset && !clear && report_valid === 1'b1 && report_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_report: got %0d expected none (t=%0t)", report_index, $time);
            end else begin
                check("report_index", report_index, exp_q.pop_front());
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        exp_q.delete();
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        tick(1);
    endtask

    task automatic push_all();
        for (int b = 0; b < int'(W); b++)
            for (int g = 0; g < int'(N_GROUPS); g++)
                exp_q.push_back(64'(g * int'(W) + b));
    endtask

    initial begin
        reset = 1'b1; enable = 1'b1; clear = 1'b0; valid = '0; report_ready = 1'b1;
        tick(2);
        reset = 1'b0;
        tick(1);

        // Reset state
        @(negedge clock);
        check("rst_report_valid", 64'(report_valid), 64'd0);
        check("rst_report_index", report_index, 64'd0);
        check("rst_hit_count", 64'(hit_count), 64'd0);
        check("rst_all_covered", 64'(all_covered), 64'd0);
        tick(1);

        // Single hit: report appears two edges later for exactly one cycle
        valid[5] = 1'b1; exp_q.push_back(64'd5);
        tick(1);
        valid = '0;
        @(negedge clock);
        check("single_not_yet", 64'(report_valid), 64'd0);
        tick(1);
        @(negedge clock);
        check("single_valid", 64'(report_valid), 64'd1);
        tick(1);
        check("single_drop", 64'(report_valid), 64'd0);
        check("single_count", 64'(hit_count), 64'd1);

        // Dedup: held hit produces a single report
        do_reset();
        valid[5] = 1'b1; exp_q.push_back(64'd5);
        tick(20);
        valid = '0;
        tick(3);
        check("dedup_count", 64'(hit_count), 64'd1);

        // Round-robin, back-to-back
        do_reset();
        valid[0] = 1'b1; valid[1] = 1'b1; valid[20] = 1'b1; valid[45] = 1'b1;
        exp_q.push_back(64'd0); exp_q.push_back(64'd20);
        exp_q.push_back(64'd45); exp_q.push_back(64'd1);
        tick(1);
        valid = '0;
        tick(1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            check("rr_back_to_back", 64'(report_valid), 64'd1);
        end
        tick(1);
        check("rr_done_valid", 64'(report_valid), 64'd0);
        check("rr_count", 64'(hit_count), 64'd4);

        // Backpressure holds slot, pending survives
        do_reset();
        report_ready = 1'b0;
        valid[0] = 1'b1; valid[1] = 1'b1; valid[20] = 1'b1; valid[45] = 1'b1;
        exp_q.push_back(64'd0); exp_q.push_back(64'd20);
        exp_q.push_back(64'd45); exp_q.push_back(64'd1);
        tick(1);
        valid = '0;
        tick(1);
        check("bp_index_start", report_index, 64'd0);
        tick(9);
        check("bp_valid_held", 64'(report_valid), 64'd1);
        check("bp_index_held", report_index, 64'd0);
        check("bp_count_zero", 64'(hit_count), 64'd0);
        report_ready = 1'b1;
        tick(5);
        check("bp_count", 64'(hit_count), 64'd4);
        check("bp_done_valid", 64'(report_valid), 64'd0);

        // Clear mid-drain after three reports
        do_reset();
        valid = '1;
        exp_q.push_back(64'd0); exp_q.push_back(64'd20); exp_q.push_back(64'd40);
        tick(1);
        valid = '0;
        tick(4);
        check("clr_pre_index", report_index, 64'd60);
        clear = 1'b1;
        tick(1);
        clear = 1'b0;
        check("clr_valid", 64'(report_valid), 64'd0);
        check("clr_count", 64'(hit_count), 64'd0);
        tick(10);
        check("clr_quiet_count", 64'(hit_count), 64'd0);
        valid[0] = 1'b1; exp_q.push_back(64'd0);
        tick(1);
        valid = '0;
        tick(4);
        check("clr_rehit_count", 64'(hit_count), 64'd1);

        // Full coverage
        do_reset();
        valid = '1; push_all();
        tick(1);
        valid = '0;
        tick(85);
        check("full_count", 64'(hit_count), 64'(P));
        check("full_all_covered", 64'(all_covered), 64'd1);
        check("full_valid", 64'(report_valid), 64'd0);
        check("full_queue", 64'(exp_q.size()), 64'd0);
        clear = 1'b1;
        tick(1);
        clear = 1'b0;
        check("full_clr_all_covered", 64'(all_covered), 64'd0);

        // Async reset mid-drain, between edges
        valid = '1; push_all();
        tick(1);
        valid = '0;
        tick(30);
        check("ar_pre_valid", 64'(report_valid), 64'd1);
        #2;
        reset = 1'b1;
        #1;
        check("ar_valid", 64'(report_valid), 64'd0);
        check("ar_index", report_index, 64'd0);
        check("ar_count", 64'(hit_count), 64'd0);
        check("ar_all_covered", 64'(all_covered), 64'd0);
        exp_q.delete();
        tick(2);
        reset = 1'b0;
        tick(5);
        check("ar_after_valid", 64'(report_valid), 64'd0);
        check("end_queue", 64'(exp_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/toggle_cover_scheduler.md
Name: toggle_cover_scheduler

Overview:
- Collects toggle-coverage hit bits from N_GROUPS monitored groups of W bits each.
- Reports each point only on its first hit since the last clear.
- Emits reports one at a time through a single valid/ready port, which feeds the coverage-report sink (DPI bridge or formal collector).
- Shares that sink between the groups with round-robin arbitration, and tracks how many points are covered.

Parameters:
- W, 20, bits per group.
- N_GROUPS, 4, number of groups; total points P = N_GROUPS*W.
- COVER_INDEX, 0, global index of point 0.
- IDX_W, 64, width of report_index.
- CNT_W, clog2(P+1), width of hit_count.

Ports:
- clock  in  1  sole clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  when low, valid is ignored; draining continues.
- clear  in  1  one-cycle pulse: forget all coverage.
- valid  in  P  hit bits; bit g*W+b is point b of group g.
- report_valid  out  1  report slot holds an index.
- report_index  out  IDX_W  COVER_INDEX + g*W + b.
- report_ready  in  1  sink accepts when high together with report_valid.
- hit_count  out  CNT_W  number of covered (acknowledged) points.
- all_covered  out  1  high when hit_count == P.

Behaviour:
- State:
  - covered[P]: acknowledged points.
  - pending[P]: hit, not yet moved to the slot.
  - slot: report_valid plus point id.
  - rr_ptr: group pointer, clog2(N_GROUPS) bits.
  - hit_count.
- Reset (async, immediate): covered=0, pending=0, report_valid=0, report_index=0, rr_ptr=0, hit_count=0, all_covered=0.
- Capture:
  - new = valid & ~covered & ~pending & ~slot_onehot, gated by enable and !reset.
  - Each edge sets pending |= new.
  - A point already covered, pending or in the slot generates nothing.
- Handshake: report_valid & report_ready at an edge sets covered[slot point], increments hit_count by 1, and frees the slot.
- Slot load: at an edge where the slot is empty or handshaking, the slot loads the selected pending point and clears that pending bit. report_valid=1 if a point was selected, else 0.
- Selection:
  - The first group with any pending bit, searching from rr_ptr upward with wrap N_GROUPS-1 -> 0.
  - Within that group, the lowest-index bit.
  - After a load from group g, rr_ptr = (g+1) mod N_GROUPS.
  - Selection uses pending as registered before the edge. A hit captured at edge k is loadable at edge k+1, so report_valid rises in the cycle after edge k+1 (2-cycle latency from valid to report).
- Back-to-back: with report_ready held high, one report per cycle. No bubbles while pending is non-empty.
- Stall: report_valid=1 with report_ready=0 holds report_index stable. New hits accumulate in pending without loss; pending cannot overflow.
- clear:
  - Takes priority over everything in that cycle.
  - At the edge: covered=0, pending=0, report_valid=0, hit_count=0. rr_ptr is unchanged.
  - valid in the clear cycle is ignored.
  - A handshake in the clear cycle is dropped (no count).
- Simultaneous handshake and re-hit of the slot point: the re-hit is ignored and the point becomes covered.
- Arithmetic:
  - report_index = COVER_INDEX + g*W + b, computed in IDX_W bits, wrapping modulo 2^IDX_W.
  - hit_count never exceeds P; no saturation logic is needed.
- all_covered is registered and equals (hit_count == P) after each edge.

Test Plan:
- Single hit: reset, set valid[5]=1 for 1 cycle, ready=1 -> report_valid high 2 cycles later for exactly 1 cycle, index 5, hit_count 0->1.
- Dedup: hold valid[5]=1 for 20 cycles -> exactly one report (index 5); hit_count=1.
- Round-robin across groups (W=20, N_GROUPS=4, ready=1): one cycle with valid bits 0, 1, 20, 45 -> report order 0, 20, 45, 1 on consecutive cycles.
- Backpressure: same stimulus with ready=0 for 10 cycles -> index 0 held stable, pending intact. Release ready -> remaining reports 20, 45, 1 follow back-to-back; hit_count=4.
- Clear mid-drain:
  - Assert all P bits, ready=1, and pulse clear after 3 reports -> report_valid=0 and hit_count=0 the next cycle; no further reports.
  - Re-hitting valid[0] afterwards -> reported again.
- Full coverage and async reset:
  - Drive all P bits with ready=1 -> 80 reports, all_covered=1.
  - Assert reset asynchronously mid-drain (between clock edges) -> all outputs reach their reset values before the next edge.
